demux_8_2_buffered: RTL and testbench

Buffered 1-to-4 byte demultiplexer: the write-side counterpart of the 4-input byte multiplexer. A single 8-bit producer stream is steered by a 2-bit select into one of four per-destination FIFOs. Each destination drains its own FIFO through an independent valid/ready handshake. It sits between the processor's byte bus and the four peripheral/register-file write ports, so a slow destination never corrupts traffic to the others.

---
 rtl/demux_pkg.sv | 14 +
 rtl/demux_8_2_buffered_byte_fifo.sv | 70 +++++++
 rtl/demux_8_2_buffered.sv | 45 ++++
 tb/tb_demux_8_2_buffered.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants and helpers for the buffered 1-to-4 byte demultiplexer.
package demux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
  localparam int BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  function automatic int unsigned ch_offset(input int unsigned ch);
    return ch * BYTE_W;
  endfunction

endpackage

// File: rtl/demux_8_2_buffered_byte_fifo.sv
// DEPTH-entry synchronous byte FIFO; head is the entry at the read pointer.
module byte_fifo
  import demux_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  logic  pop,
  input  byte_t wr_data,
  output logic  full,
  output logic  empty,
  output byte_t head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  byte_t            mem_q [DEPTH];
  byte_t            mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    // A simultaneous push and pop leaves the occupancy unchanged.
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/demux_8_2_buffered.sv
// Steers one byte stream into four per-destination FIFOs drained independently.
module demux_8_2_buffered
  import demux_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [BYTE_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [NUM_CH*BYTE_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready
);

  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] push_en;
  byte_t             head [NUM_CH];

  // Readiness depends only on the selected channel's fill state, never on out_ready.
  assign in_ready  = !full[in_sel];
  assign out_valid = ~empty;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign push_en[k] = in_valid && in_ready && (in_sel == SEL_W'(k));
    assign out_data[ch_offset(k) +: BYTE_W] = head[k];

    byte_fifo #(
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .push   (push_en[k]),
      .pop    (out_ready[k]),
      .wr_data(in_data),
      .full   (full[k]),
      .empty  (empty[k]),
      .head   (head[k])
    );
  end

endmodule

// File: tb/tb_demux_8_2_buffered.sv
// Self-checking bench: queue-based reference model plus directed and random traffic.
module tb_demux_8_2_buffered;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;

  int checks = 0;
  int errors = 0;

  logic [7:0] model [4][$];
  logic [7:0] recv  [4][$];

  demux_8_2_buffered #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check DUT against the model mid-cycle, then advance the model at the edge.
  task automatic applyStimulus(output bit accepted);
    logic [31:0] obs_d;
    logic [3:0]  obs_v;
    @(negedge clk);
    obs_d = out_data;
    obs_v = out_valid;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("valid%0d", k), 32'(obs_v[k]), 32'(model[k].size() != 0));
      if (model[k].size() != 0)
        checkOutput($sformatf("data%0d", k), 32'(obs_d[8*k +: 8]), 32'(model[k][0]));
    end
    checkOutput("in_ready", 32'(in_ready), 32'(model[in_sel].size() < DEPTH));
    @(posedge clk);
    accepted = in_valid && (model[in_sel].size() < DEPTH);
    for (int k = 0; k < 4; k++) begin
      if (obs_v[k] && out_ready[k]) recv[k].push_back(obs_d[8*k +: 8]);
      if (model[k].size() != 0 && out_ready[k]) void'(model[k].pop_front());
    end
    if (accepted) model[in_sel].push_back(in_data);
    #1;
  endtask

  task automatic resetDut();
    bit acc;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_sel    = 2'd0;
    out_ready = 4'b0000;
    rst_n     = 1'b0;
    for (int k = 0; k < 4; k++) begin
      model[k].delete();
      recv[k].delete();
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_data", out_data, 32'h0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(acc);
  endtask

  initial begin
    bit acc;
    int idx;
    int guard;
    logic [7:0] exp_bytes [$];

    $display("[TB] start");
    resetDut();

    // Asynchronous reset while data is held.
    in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h5A;
    applyStimulus(acc);
    in_valid = 1'b0;
    applyStimulus(acc);
    checkOutput("preload_valid", 32'(out_valid), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_valid", 32'(out_valid), 32'h0);
    checkOutput("async_data", out_data, 32'h0);
    checkOutput("async_in_ready", 32'(in_ready), 32'h1);
    resetDut();

    // Single route to channel 2.
    in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hA5;
    applyStimulus(acc);
    in_valid = 1'b0;
    applyStimulus(acc);
    checkOutput("route_valid", 32'(out_valid), 32'h4);
    checkOutput("route_data", out_data, 32'h00A5_0000);

    // Fill channel 1 and observe backpressure.
    resetDut();
    in_valid = 1'b1; in_sel = 2'd1;
    in_data = 8'h11; applyStimulus(acc);
    in_data = 8'h22; applyStimulus(acc);
    in_valid = 1'b0;
    #1;
    checkOutput("full_ready_ch1", 32'(in_ready), 32'h0);
    in_sel = 2'd0;
    #1;
    checkOutput("full_ready_ch0", 32'(in_ready), 32'h1);
    out_ready = 4'b0010;
    repeat (3) applyStimulus(acc);
    exp_bytes = '{8'h11, 8'h22};
    checkOutput("drain_ch1", 32'(recv[1] == exp_bytes), 32'h1);
    checkOutput("drain_ch1_empty", 32'(out_valid[1]), 32'h0);

    // Simultaneous push and pop on channel 3.
    resetDut();
    in_valid = 1'b1; in_sel = 2'd3; in_data = 8'h30;
    applyStimulus(acc);
    in_data = 8'h31; out_ready = 4'b1000;
    applyStimulus(acc);
    in_valid = 1'b0; out_ready = 4'b0000;
    applyStimulus(acc);
    checkOutput("pp_valid", 32'(out_valid[3]), 32'h1);
    checkOutput("pp_head", 32'(out_data[31:24]), 32'h31);
    out_ready = 4'b1000;
    applyStimulus(acc);
    out_ready = 4'b0000;
    applyStimulus(acc);
    checkOutput("pp_count1", 32'(out_valid[3]), 32'h0);

    // Wrap-around on channel 0 with toggling out_ready.
    resetDut();
    idx = 1; guard = 0;
    in_sel = 2'd0;
    while (idx <= 5 && guard < 40) begin
      in_valid  = 1'b1;
      in_data   = 8'(idx);
      out_ready = {3'b000, guard[0]};
      applyStimulus(acc);
      if (acc) idx++;
      guard++;
    end
    in_valid = 1'b0; out_ready = 4'b0001;
    repeat (4) applyStimulus(acc);
    exp_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    checkOutput("wrap_order", 32'(recv[0] == exp_bytes), 32'h1);

    // Channel 2 streams while channel 0 sits full.
    resetDut();
    in_valid = 1'b1; in_sel = 2'd0;
    in_data = 8'hE0; applyStimulus(acc);
    in_data = 8'hE1; applyStimulus(acc);
    out_ready = 4'b0100; in_sel = 2'd2;
    idx = 0; guard = 0;
    while (idx < 4 && guard < 40) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h40 + idx);
      applyStimulus(acc);
      if (acc) idx++;
      guard++;
    end
    in_valid = 1'b0;
    repeat (3) applyStimulus(acc);
    exp_bytes = '{8'h40, 8'h41, 8'h42, 8'h43};
    checkOutput("indep_ch2", 32'(recv[2] == exp_bytes), 32'h1);
    checkOutput("indep_ch0_head", 32'(out_data[7:0]), 32'hE0);
    checkOutput("indep_ch0_valid", 32'(out_valid[0]), 32'h1);

    // Random traffic; the producer holds sel/data until accepted.
    resetDut();
    in_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!in_valid || acc) begin
        in_valid = 1'($urandom_range(0, 3) != 0);
        in_sel   = 2'($urandom_range(0, 3));
        in_data  = 8'($urandom);
      end
      out_ready = 4'($urandom);
      applyStimulus(acc);
    end
    in_valid = 1'b0; out_ready = 4'b1111;
    repeat (DEPTH + 1) applyStimulus(acc);
    checkOutput("final_empty", 32'(out_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
